// File: rtl/multiplier_pipe.sv
// multiplier_pipe: WIDTH x WIDTH signed/unsigned multiplier with run/stall handshake, LAT-cycle stall.
// Optional accumulator built when MUL_ACC_EN is defined.
module multiplier_pipe #(
    parameter int WIDTH = 32,
    parameter int LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               u,
    input  logic               acc,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               stall,
    output logic [2*WIDTH-1:0] z
);
    localparam int unsigned N  = WIDTH / 16;
    localparam int unsigned T  = N * N;
    localparam int unsigned G  = (LAT > 1) ? LAT - 1 : 1;
    localparam int unsigned ZW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_n;
    logic [2:0]    cnt, cnt_n;
    logic          start, finish;
    logic [ZW-1:0] pp_live [T];
    logic [ZW-1:0] pp_q [T];
    logic [ZW-1:0] psum_q, full_sum, grp_sum, p;

    // 18x18 chunk product; only the top chunk carries the operand sign.
    function automatic logic [ZW-1:0] chunk_product(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sgn,
        input int unsigned      i,
        input int unsigned      j
    );
        logic signed [17:0] ca, cb;
        logic signed [35:0] pr;
        logic [ZW+35:0]     ext;
        ca  = {{2{sgn & (i == N - 1) & a[16*i+15]}}, a[16*i +: 16]};
        cb  = {{2{sgn & (j == N - 1) & b[16*j+15]}}, b[16*j +: 16]};
        pr  = ca * cb;
        ext = {{ZW{pr[35]}}, pr};
        ext = ext << (16 * (i + j));
        return ext[ZW-1:0];
    endfunction

    always_comb begin
        pp_live = '{default: '0};
        for (int unsigned i = 0; i < N; i++)
            for (int unsigned j = 0; j < N; j++)
                pp_live[i*N+j] = chunk_product(x, y, u, i, j);
    end

    always_comb begin
        full_sum = '0;
        for (int unsigned k = 0; k < T; k++)
            full_sum = full_sum + pp_live[k];
    end

    // Each BUSY cycle folds in one interleaved group of the registered partial products.
    always_comb begin
        grp_sum = '0;
        for (int unsigned k = 0; k < T; k++)
            if ((k % G) + 1 == 32'(cnt))
                grp_sum = grp_sum + pp_q[k];
    end

    assign p = (LAT == 1) ? full_sum : psum_q + grp_sum;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (run) begin
                    if (LAT == 1) begin
                        state_n = DONE;
                    end else begin
                        state_n = BUSY;
                        cnt_n   = 3'd1;
                    end
                end
            end
            BUSY: begin
                if (cnt == 3'(LAT - 1)) state_n = DONE;
                else                    cnt_n   = cnt + 3'd1;
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign start  = (state == IDLE) && run;
    assign finish = (state_n == DONE);
    assign stall  = !rst && run && (state != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            pp_q   <= pp_live;
            psum_q <= '0;
        end else if (state == BUSY) begin
            psum_q <= psum_q + grp_sum;
        end
    end

`ifdef MUL_ACC_EN
    logic          acc_q, acc_sel;
    logic [ZW-1:0] a_q;

    // With LAT=1 completion coincides with capture, so the live request applies.
    assign acc_sel = (state == IDLE) ? acc : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 1'b0;
            a_q   <= '0;
        end else begin
            if (start)  acc_q <= acc;
            if (finish) a_q   <= acc_sel ? a_q + p : p;
        end
    end

    assign z = a_q;
`else
    logic unused_acc;
    assign unused_acc = acc;

    always_ff @(posedge clk) begin
        if (rst)         z <= '0;
        else if (finish) z <= p;
    end
`endif

endmodule

// File: tb/tb_multiplier_pipe.sv
// Scoreboard bench for multiplier_pipe: drivers push expected products, negedge monitors pop and compare.
module tb_multiplier_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [127:0] q1[$], q3[$], q4[$], qa[$];

    logic        run1 = 0, u1 = 0, acc1 = 0, st1;
    logic [31:0] x1 = '0, y1 = '0;
    logic [63:0] z1;
    logic        run3 = 0, u3 = 0, acc3 = 0, st3, rst3p = 0;
    logic [31:0] x3 = '0, y3 = '0;
    logic [63:0] z3;
    logic        run4 = 0, u4 = 0, acc4 = 0, st4;
    logic [63:0] x4 = '0, y4 = '0;
    logic [127:0] z4;

    multiplier_pipe #(.WIDTH(32), .LAT(1)) d1 (
        .clk(clk), .rst(rst), .run(run1), .u(u1), .acc(acc1),
        .x(x1), .y(y1), .stall(st1), .z(z1));
    multiplier_pipe #(.WIDTH(32), .LAT(3)) d3 (
        .clk(clk), .rst(rst | rst3p), .run(run3), .u(u3), .acc(acc3),
        .x(x3), .y(y3), .stall(st3), .z(z3));
    multiplier_pipe #(.WIDTH(64), .LAT(4)) d4 (
        .clk(clk), .rst(rst), .run(run4), .u(u4), .acc(acc4),
        .x(x4), .y(y4), .stall(st4), .z(z4));

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: result with empty scoreboard, want none", name);
    endtask

    int sc1 = 0, sc3 = 0, sc4 = 0;
    always @(negedge clk) begin
        if (rst) sc1 = 0;
        else if (run1 && st1) sc1++;
        else if (run1) begin
            check("d1 stall cycles", 128'(sc1), 128'd1);
            if (q1.size() == 0) unexpected("d1 product");
            else check("d1 product", 128'(z1), q1.pop_front());
            sc1 = 0;
        end
    end
    always @(negedge clk) begin
        if (rst || rst3p) sc3 = 0;
        else if (run3 && st3) sc3++;
        else if (run3) begin
            check("d3 stall cycles", 128'(sc3), 128'd3);
            if (q3.size() == 0) unexpected("d3 product");
            else check("d3 product", 128'(z3), q3.pop_front());
            sc3 = 0;
        end
    end
    always @(negedge clk) begin
        if (rst) sc4 = 0;
        else if (run4 && st4) sc4++;
        else if (run4) begin
            check("d4 stall cycles", 128'(sc4), 128'd4);
            if (q4.size() == 0) unexpected("d4 product");
            else check("d4 product", z4, q4.pop_front());
            sc4 = 0;
        end
    end

`ifdef MUL_ACC_EN
    logic        runa = 0, ua = 0, acca = 0, sta;
    logic [15:0] xa = '0, ya = '0;
    logic [31:0] za;
    int          sca = 0;

    multiplier_pipe #(.WIDTH(16), .LAT(2)) da (
        .clk(clk), .rst(rst), .run(runa), .u(ua), .acc(acca),
        .x(xa), .y(ya), .stall(sta), .z(za));

    always @(negedge clk) begin
        if (rst) sca = 0;
        else if (runa && sta) sca++;
        else if (runa) begin
            check("da stall cycles", 128'(sca), 128'd2);
            if (qa.size() == 0) unexpected("da sum");
            else check("da sum", 128'(za), qa.pop_front());
            sca = 0;
        end
    end
`endif

    function automatic int qsize(input int which);
        case (which)
            1:       return q1.size();
            3:       return q3.size();
            4:       return q4.size();
            default: return qa.size();
        endcase
    endfunction

    // Waits for the monitor to consume the pending result; returns #1 after the DONE->IDLE edge.
    task automatic drain(input int which, input string name);
        int n = 0;
        while (qsize(which) != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (qsize(which) != 0) begin
            total++;
            bad++;
            $display("FAIL %s timeout: pending=%0d want=0", name, qsize(which));
            case (which)
                1:       q1.delete();
                3:       q3.delete();
                4:       q4.delete();
                default: qa.delete();
            endcase
        end
        #1;
    endtask

    task automatic op1(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [127:0] e);
        x1 = a; y1 = b; u1 = s; run1 = 1'b1;
        q1.push_back(e);
        drain(1, "d1");
    endtask

    task automatic op3(input logic [31:0] a, input logic [31:0] b, input logic s, input logic scr,
                       input logic [127:0] e);
        x3 = a; y3 = b; u3 = s; run3 = 1'b1;
        q3.push_back(e);
        if (scr) begin
            @(posedge clk); #1;
            x3 = 32'hDEADBEEF;
            y3 = 32'h00000005;
        end
        drain(3, "d3");
    endtask

    task automatic op4(input logic [63:0] a, input logic [63:0] b, input logic s, input logic [127:0] e);
        x4 = a; y4 = b; u4 = s; run4 = 1'b1;
        q4.push_back(e);
        drain(4, "d4");
    endtask

`ifdef MUL_ACC_EN
    task automatic opa(input logic [15:0] a, input logic [15:0] b, input logic s, input logic ac,
                       input logic [127:0] e);
        xa = a; ya = b; ua = s; acca = ac; runa = 1'b1;
        qa.push_back(e);
        drain(5, "da");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired");
        $fatal(1, "watchdog");
    end

    initial begin
        run1 = 1'b1; run3 = 1'b1; run4 = 1'b1;
`ifdef MUL_ACC_EN
        runa = 1'b1;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset stall d1", 128'(st1), 128'd0);
        check("reset stall d3", 128'(st3), 128'd0);
        check("reset stall d4", 128'(st4), 128'd0);
        check("reset z d1", 128'(z1), 128'd0);
        check("reset z d3", 128'(z3), 128'd0);
        check("reset z d4", z4, 128'd0);
        @(posedge clk); #1;
        run1 = 1'b0; run3 = 1'b0; run4 = 1'b0;
`ifdef MUL_ACC_EN
        runa = 1'b0;
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        op1(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 128'h0000000000000000_FFFFFFFE00000001);
        op1(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 128'h0000000000000000_0000000000000001);
        op1(32'h80000000, 32'h80000000, 1'b1, 128'h0000000000000000_4000000000000000);
        op1(32'hFFFFFFFE, 32'h00000003, 1'b1, 128'h0000000000000000_FFFFFFFFFFFFFFFA);
        op1(32'hFFFFFFFE, 32'h00000003, 1'b0, 128'h0000000000000000_00000002FFFFFFFA);
        run1 = 1'b0;

        op3(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 128'h0000000000000000_0B00EA4E242D2080);
        op3(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 128'h0000000000000000_0B00EA4E242D2080);
        op3(32'hFFFFFFFE, 32'h00000003, 1'b1, 1'b0, 128'h0000000000000000_FFFFFFFFFFFFFFFA);

        // Abort an operation in its first BUSY cycle.
        x3 = 32'd7; y3 = 32'd9; u3 = 1'b0; run3 = 1'b1;
        @(posedge clk); #1;
        check("d3 z hold while busy", 128'(z3), 128'h0000000000000000_FFFFFFFFFFFFFFFA);
        rst3p = 1'b1;
        @(negedge clk);
        check("d3 stall during rst", 128'(st3), 128'd0);
        @(posedge clk); #1;
        rst3p = 1'b0;
        check("d3 z after rst", 128'(z3), 128'd0);
        op3(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 128'h0000000000000000_FFFFFFFE00000001);
        run3 = 1'b0;

        op4(64'hFFFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, 1'b1, 128'hFFFFFFFFFFFFFFFF_8000000000000001);
        op4(64'hFFFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, 1'b0, 128'h7FFFFFFFFFFFFFFE_8000000000000001);
        op4(64'hFFFFFFFFFFFFFFFF, 64'h0000000000000002, 1'b0, 128'h0000000000000001_FFFFFFFFFFFFFFFE);
        run4 = 1'b0;

`ifdef MUL_ACC_EN
        opa(16'd3, 16'd4, 1'b0, 1'b0, 128'd12);
        opa(16'd5, 16'd6, 1'b0, 1'b1, 128'd42);
        opa(16'hFFFE, 16'd3, 1'b1, 1'b1, 128'd36);
        runa = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multiplier_pipe.md
Name: multiplier_pipe

Overview:
- Parametrised successor to the single-cycle-stall integer multiplier in the RISC5 execute stage.
- Computes the full 2*WIDTH-bit signed or unsigned product of two WIDTH-bit operands.
- Result appears after a configurable LAT-cycle stall. Built from 16-bit partial products summed through an internal pipeline.
- Keeps the run/stall handshake the CPU already uses, so it drops into the existing MUL path.

Parameters:
- WIDTH, 32, operand width; must be a multiple of 16, range 16..64.
- LAT, 1, stall cycles per operation, range 1..4. Partial-product sums are spread across LAT register stages.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  CPU requests a multiply; held high until stall falls.
- u  in  1  1 = two's-complement signed operands, 0 = unsigned.
- acc  in  1  accumulate request; used only with MUL_ACC_EN.
- x  in  WIDTH  multiplicand.
- y  in  WIDTH  multiplier.
- stall  out  1  holds the CPU pipeline while a result is pending.
- z  out  2*WIDTH  product, or accumulated sum.

Behaviour:
- Reset: rst high on a clock edge sets state IDLE, cnt=0, z=0 and the accumulator to 0. While rst is high, stall=0. Reset aborts any operation in flight; no partial result is written to z.
- FSM states:
  - IDLE: stall = run. If run=1, latch x, y, u, acc into operand registers and start the pipeline. Go to DONE if LAT=1, else go to BUSY with cnt=1.
  - BUSY: stall = run. cnt increments each cycle; when cnt = LAT-1, go to DONE.
  - DONE: stall=0 and z holds the new result this cycle. Next state is always IDLE.
- Stall timing: with run held high, stall is high for exactly LAT cycles, then low for one cycle (DONE). The CPU captures z in that DONE cycle.
- Back-to-back: if run is still high in the cycle after DONE, a new operation starts from IDLE. Throughput is one result per LAT+1 cycles.
- Operand capture: x, y, u and acc are captured only on IDLE->start. Changes while BUSY are ignored.
- run dropping mid-operation: the operation completes and z is updated anyway, but stall follows run and goes low immediately.
- Product construction:
  - Operands split into 16-bit chunks. Chunk products use 18-bit operands.
  - The top chunk is sign-extended by u&msb; lower chunks are zero-extended.
  - Shifted chunk products are summed modulo 2^(2*WIDTH).
  - Result must equal x*y, signed when u=1 and unsigned when u=0.
- z update: z changes only on the edge entering DONE; it holds its value in IDLE and BUSY. z is registered and has no combinational path from x or y.

Optional Feature:
- Macro: MUL_ACC_EN.
- Enabled: a 2*WIDTH-bit accumulator register A, with z driven from A.
  - On completion, A <= A + P if the latched acc=1, else A <= P. Addition wraps modulo 2^(2*WIDTH).
  - u also selects the signedness of P.
  - A is cleared only by rst.
- Disabled: no accumulator is built, acc is ignored, and z <= P on completion.

Test Plan:
- WIDTH=32, LAT=1, u=0, x=y=0xFFFFFFFF, run high: stall=1 for 1 cycle, then stall=0 with z=0xFFFFFFFE00000001. Same operands with u=1: z=0x0000000000000001.
- WIDTH=32, LAT=1, u=1, x=y=0x80000000 -> z=0x4000000000000000. Then u=1, x=0xFFFFFFFE (-2), y=3 -> z=0xFFFFFFFFFFFFFFFA.
- WIDTH=32, LAT=3, run held high 8 cycles, x=0x12345678, y=0x9ABCDEF0, u=0: stall pattern 1,1,1,0,1,1,1,0; z=0x0B00EA4E242D2080 in each DONE cycle. Changing x in cycle 1 does not affect z.
- WIDTH=32, LAT=3, rst pulsed in cycle 1 of an operation: stall=0 during rst, z=0 after, FSM in IDLE. The next run gives a correct product after 3 stall cycles.
- MUL_ACC_EN, WIDTH=16, LAT=2: 3*4 acc=0 -> z=12; 5*6 acc=1 -> z=42; u=1 (-2)*3 acc=1 -> z=36.
- WIDTH=64, LAT=4, u=1, x=-1, y=0x7FFFFFFFFFFFFFFF -> z=0xFFFFFFFFFFFFFFFF8000000000000001 after 4 stall cycles.
